tff_chain: RTL and testbench

TFF_CHAIN -- requirements
Module: tff_chain

---
 rtl/tff_chain_pkg.sv | 13 +
 rtl/tff_stage.sv | 42 ++++
 rtl/tff_chain.sv | 91 +++++++++
 tb/tb_tff_chain.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tff_chain_pkg.sv
// Shared constants for the cascaded toggle / delay-line chain.
// Mode encodings are visible to both the stage register and the top.
package tff_chain_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_DELAY  = 1'b1;

    // One lane-vector step of a stage, shared so the top can predict q's next value.
    function automatic logic stage_bit_next(input logic mode, input logic cur, input logic din);
        return (mode == MODE_DELAY) ? din : (cur ^ din);
    endfunction

endpackage

// File: rtl/tff_stage.sv
// One WIDTH-bit stage of the chain: T flip-flops in toggle mode, D flip-flops in delay mode.
// Holds while en is low; synchronous active-high reset clears every lane.
module tff_stage
    import tff_chain_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // Lanes are built separately so no lane can ever see another lane's data.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            always_comb begin
                q_next[gi] = q_reg[gi];
                if (en) begin
                    q_next[gi] = stage_bit_next(mode, q_reg[gi], din[gi]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/tff_chain.sv
// Cascade of STAGES tff_stage registers with a tap bus and a saturating counter
// of enabled edges on which the last stage changes value.
module tff_chain
    import tff_chain_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          data,
    input  logic                      cnt_clr,
    output logic [WIDTH-1:0]          q,
    output logic [STAGES*WIDTH-1:0]   taps,
    output logic [CNT_W-1:0]          chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] stage_in [STAGES];
    logic [WIDTH-1:0] stage_q  [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_in[gi] = data;
            end else begin : g_link
                assign stage_in[gi] = stage_q[gi-1];
            end

            tff_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .mode (mode),
                .din  (stage_in[gi]),
                .q    (stage_q[gi])
            );

            assign taps[gi*WIDTH +: WIDTH] = stage_q[gi];
        end
    endgenerate

    assign q = stage_q[STAGES-1];

    // Predicted next value of q, used only to decide whether this edge changes q.
    logic [WIDTH-1:0] q_next;
    logic             q_changed;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_qnext
            always_comb begin
                q_next[gi] = q[gi];
                if (en) begin
                    q_next[gi] = stage_bit_next(mode, q[gi], stage_in[STAGES-1][gi]);
                end
            end
        end
    endgenerate

    assign q_changed = (q_next != q);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (q_changed && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign chg_cnt = cnt_reg;

endmodule

// File: tb/tb_tff_chain.sv
// Scoreboard bench for tff_chain: two instances (4-lane x 2-stage, 1-lane x 3-stage with a
// 2-bit counter) driven by directed vectors; a monitor checks each edge against hand values.
module tb_tff_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, STAGES=2, CNT_W=8
    logic       a_rst, a_en, a_mode, a_clr;
    logic [3:0] a_data, a_q;
    logic [7:0] a_taps, a_cnt;

    // Instance B: WIDTH=1, STAGES=3, CNT_W=2
    logic       b_rst, b_en, b_mode, b_clr;
    logic [0:0] b_data, b_q;
    logic [2:0] b_taps;
    logic [1:0] b_cnt;

    tff_chain #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .data(a_data),
        .cnt_clr(a_clr), .q(a_q), .taps(a_taps), .chg_cnt(a_cnt)
    );

    tff_chain #(.WIDTH(1), .STAGES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .data(b_data),
        .cnt_clr(b_clr), .q(b_q), .taps(b_taps), .chg_cnt(b_cnt)
    );

    typedef struct {
        string      tag;
        logic       ca;
        logic [7:0] ta;
        logic [7:0] ca_cnt;
        logic       cb;
        logic [2:0] tbv;
        logic [1:0] cb_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every output edge presents a new state; pop the matching expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.ca) begin
                chk({e.tag, "_a_taps"}, a_taps, e.ta);
                chk({e.tag, "_a_q"}, {4'h0, a_q}, {4'h0, e.ta[7:4]});
                chk({e.tag, "_a_cnt"}, a_cnt, e.ca_cnt);
            end
            if (e.cb) begin
                chk({e.tag, "_b_taps"}, {5'h0, b_taps}, {5'h0, e.tbv});
                chk({e.tag, "_b_q"}, {7'h0, b_q}, {7'h0, e.tbv[2]});
                chk({e.tag, "_b_cnt"}, {6'h0, b_cnt}, {6'h0, e.cb_cnt});
            end
            $display("edge %-10s a_taps=%h a_cnt=%0d b_taps=%b b_cnt=%0d",
                     e.tag, a_taps, a_cnt, b_taps, b_cnt);
        end
    end

    task automatic step(input string tag, input logic ca, input logic [7:0] ta, input logic [7:0] cnta,
                        input logic cb, input logic [2:0] tbv, input logic [1:0] cntb);
        exp_t e;
        e.tag = tag; e.ca = ca; e.ta = ta; e.ca_cnt = cnta;
        e.cb = cb; e.tbv = tbv; e.cb_cnt = cntb;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Two-stage toggle pair with data=1 on lane 0: taps {stage1, stage0} and counts per edge.
    logic [7:0] tog_taps [11];
    logic [7:0] tog_cnt  [11];
    logic [7:0] lane_taps [8];
    logic [2:0] dly_taps [4];
    logic [1:0] dly_cnt  [4];
    logic [2:0] sat_taps [8];
    logic [1:0] sat_cnt  [8];

    initial begin
        tog_taps  = '{8'h01, 8'h10, 8'h11, 8'h00, 8'h01, 8'h10, 8'h11, 8'h00, 8'h01, 8'h10, 8'h11};
        tog_cnt   = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5, 8'd5};
        lane_taps = '{8'h05, 8'h50, 8'h55, 8'h00, 8'h05, 8'h50, 8'h55, 8'h00};
        dly_taps  = '{3'b010, 3'b100, 3'b000, 3'b000};
        dly_cnt   = '{2'd0, 2'd1, 2'd2, 2'd2};
        sat_taps  = '{3'b001, 3'b010, 3'b111, 3'b000, 3'b001, 3'b010, 3'b111, 3'b000};
        sat_cnt   = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

        a_rst = 1'b1; a_en = 1'b1; a_mode = 1'b0; a_clr = 1'b1; a_data = 4'hF;
        b_rst = 1'b1; b_en = 1'b1; b_mode = 1'b1; b_clr = 1'b0; b_data = 1'b1;
        @(negedge clk);

        // Reset overrides en/mode/data/cnt_clr
        step("reset", 1, 8'h00, 8'd0, 1, 3'b000, 2'd0);
        a_rst = 1'b0; a_en = 1'b0; a_clr = 1'b0; a_data = 4'h0;
        b_rst = 1'b0;

        // B: single-edge pulse walks through the delay line
        b_mode = 1'b1; b_en = 1'b1; b_data = 1'b1;
        step("dly_in", 0, 8'h00, 8'd0, 1, 3'b001, 2'd0);
        b_data = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("dly%0d", i), 0, 8'h00, 8'd0, 1, dly_taps[i], dly_cnt[i]);

        // B: three-stage toggle cascade drives the 2-bit counter into saturation
        b_mode = 1'b0; b_data = 1'b1;
        for (int i = 0; i < 8; i++) step($sformatf("sat%0d", i), 0, 8'h00, 8'd0, 1, sat_taps[i], sat_cnt[i]);
        step("pre_clr0", 0, 8'h00, 8'd0, 1, 3'b001, 2'd3);
        step("pre_clr1", 0, 8'h00, 8'd0, 1, 3'b010, 2'd3);
        b_clr = 1'b1;
        step("clr_chg", 0, 8'h00, 8'd0, 1, 3'b111, 2'd0);
        b_clr = 1'b0;
        step("post_clr", 0, 8'h00, 8'd0, 1, 3'b000, 2'd1);
        b_en = 1'b0; b_clr = 1'b1;
        step("clr_hold", 0, 8'h00, 8'd0, 1, 3'b000, 2'd0);
        b_clr = 1'b0;

        // A: toggle pair on lane 0
        a_mode = 1'b0; a_en = 1'b1; a_data = 4'h1;
        for (int i = 0; i < 11; i++) step($sformatf("tog%0d", i), 1, tog_taps[i], tog_cnt[i], 0, 3'b000, 2'd0);

        // A: freeze with junk data, then switch to delay mode without flushing
        a_en = 1'b0; a_data = 4'hF;
        for (int i = 0; i < 5; i++) step($sformatf("hold%0d", i), 1, 8'h11, 8'd5, 0, 3'b000, 2'd0);
        a_en = 1'b1; a_mode = 1'b1; a_data = 4'h0;
        step("msw0", 1, 8'h10, 8'd5, 0, 3'b000, 2'd0);
        step("msw1", 1, 8'h00, 8'd6, 0, 3'b000, 2'd0);

        // A: reset mid-stream, then the toggle sequence must repeat exactly
        a_mode = 1'b0; a_data = 4'h1;
        step("ms0", 1, 8'h01, 8'd6, 0, 3'b000, 2'd0);
        step("ms1", 1, 8'h10, 8'd7, 0, 3'b000, 2'd0);
        a_rst = 1'b1;
        step("ms_rst", 1, 8'h00, 8'd0, 0, 3'b000, 2'd0);
        a_rst = 1'b0;
        for (int i = 0; i < 8; i++) step($sformatf("rep%0d", i), 1, tog_taps[i], tog_cnt[i], 0, 3'b000, 2'd0);

        // A: lanes 0 and 2 toggle, lanes 1 and 3 stay quiet
        a_rst = 1'b1;
        step("ln_rst", 1, 8'h00, 8'd0, 0, 3'b000, 2'd0);
        a_rst = 1'b0; a_data = 4'b0101;
        for (int i = 0; i < 8; i++) step($sformatf("lane%0d", i), 1, lane_taps[i], tog_cnt[i], 0, 3'b000, 2'd0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
